// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad BCD entry block:
//   - FSM state encoding
//   - codes for the non-decimal keys
//   - key_map(): (row index, column index) -> 4-bit key code
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Physical layout:
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: * 0 # D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_bcd_entry_sync.sv
// sync_2ff
// Four-bit two-flop synchroniser for the keypad row inputs. Both stages
// reset to 1 so an idle (all-high) keypad is seen during and after reset.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   d_i  : asynchronous input bits
//   q_o  : synchronised output bits
module sync_2ff (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// pressed key, emits a one-cycle key event and shifts decimal keys into a
// 4-digit packed-BCD register (C clears, B deletes the newest digit).
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   row_n     : keypad rows, active-low, asynchronous to clk
//   col_n     : column drive, active-low, one-cold
//   bcd       : entered digits, [3:0] newest
//   key_code  : code of the last accepted key
//   key_valid : one-cycle pulse per accepted key
//
// state    | meaning
// SCAN     | rotating the column drive, waiting for any row low
// DEBOUNCE | column held, counting consecutive samples of the same row
// HELD     | key accepted, column held until all rows stay high long enough
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] bcd,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [3:0]        row_s;
    logic [SLOT_W-1:0] slot_q;
    state_e            state_q, state_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  rel_q, rel_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;

    logic       sample;
    logic       any_low;
    logic [1:0] low_idx;
    logic [1:0] cur_col_idx;
    logic [3:0] col_rot;
    logic       accept;
    logic [3:0] code;

    sync_2ff u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_n),
        .q_o (row_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (slot_q == SLOT_LAST) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign sample  = (slot_q == SLOT_LAST);
    assign any_low = ~&row_s;
    assign col_rot = {col_q[2:0], col_q[3]};

    // Lowest pressed row wins when several rows are low in one column.
    always_comb begin
        low_idx = 2'd3;
        if (!row_s[0])      low_idx = 2'd0;
        else if (!row_s[1]) low_idx = 2'd1;
        else if (!row_s[2]) low_idx = 2'd2;
    end

    always_comb begin
        case (col_q)
            4'b1110: cur_col_idx = 2'd0;
            4'b1101: cur_col_idx = 2'd1;
            4'b1011: cur_col_idx = 2'd2;
            default: cur_col_idx = 2'd3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        match_d     = match_q;
        rel_d       = rel_q;
        bcd_d       = bcd_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        accept      = 1'b0;
        code        = key_map(row_idx_q, col_idx_q);

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (!any_low) begin
                        col_d = col_rot;
                    end else begin
                        row_idx_d = low_idx;
                        col_idx_d = cur_col_idx;
                        match_d   = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            code    = key_map(low_idx, cur_col_idx);
                            rel_d   = '0;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (low_idx == row_idx_q)) begin
                        match_d = match_q + CNT_ONE;
                        if ((match_q + CNT_ONE) == CNT_DONE) begin
                            accept  = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        match_d = '0;
                        col_d   = col_rot;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (any_low) begin
                        rel_d = '0;
                    end else if ((rel_q + CNT_ONE) == CNT_DONE) begin
                        rel_d   = '0;
                        match_d = '0;
                        col_d   = col_rot;
                        state_d = SCAN;
                    end else begin
                        rel_d = rel_q + CNT_ONE;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = code;
            if (code <= 4'd9) begin
                bcd_d = {bcd_q[11:0], code};
            end else if (code == KEY_C) begin
                bcd_d = 16'h0000;
            end else if (code == KEY_B) begin
                bcd_d = {4'h0, bcd_q[15:4]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 4'b1110;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            match_q     <= '0;
            rel_q       <= '0;
            bcd_q       <= 16'h0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            bcd_q       <= bcd_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_n     = col_q;
    assign bcd       = bcd_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb_keypad_bcd_entry
// Directed bench for keypad_bcd_entry with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A small keypad model pulls the pressed rows low only while the pressed
// key's column is driven; an override drives row_n directly for bounce.
module tb_keypad_bcd_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] bcd;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [3:0]  rows_mask;
    logic [1:0]  key_col;
    logic        ovr_en;
    logic [3:0]  ovr_rows;

    int checks;
    int errors;
    int pulses;
    logic [3:0] last_code;

    keypad_bcd_entry #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .bcd       (bcd),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign row_n = ovr_en ? ovr_rows :
                   ((rows_mask != 4'h0) && (col_n[key_col] == 1'b0)) ? ~rows_mask : 4'hF;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses    = pulses + 1;
            last_code = key_code;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // One slot = 4 clocks; waits stay aligned to the negedge after a sample edge.
    task automatic slots(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic press_chk(input string tag, input int r, input int c,
                             input logic [3:0] exp_code, input logic [15:0] exp_bcd);
        int p0;
        p0        = pulses;
        rows_mask = 4'(1 << r);
        key_col   = 2'(c);
        slots(10);
        rows_mask = 4'h0;
        slots(5);
        chk({tag, "_pulses"}, 16'(pulses), 16'(p0 + 1));
        chk({tag, "_code"}, {12'h0, last_code}, {12'h0, exp_code});
        chk({tag, "_bcd"}, bcd, exp_bcd);
    endtask

    initial begin
        int p0;
        logic found;
        checks    = 0;
        errors    = 0;
        pulses    = 0;
        last_code = 4'h0;
        rows_mask = 4'h0;
        key_col   = 2'd0;
        ovr_en    = 1'b0;
        ovr_rows  = 4'hF;
        rst       = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_col", {12'h0, col_n}, 16'h000E);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_code", {12'h0, key_code}, 16'h0000);
        chk("rst_valid", {15'h0, key_valid}, 16'h0000);
        rst = 1'b0;

        // Key 5 held 10 slots: one event, then 3 high samples before rotating.
        rows_mask = 4'b0010;
        key_col   = 2'd1;
        slots(10);
        chk("k5_pulses", 16'(pulses), 16'd1);
        chk("k5_code", {12'h0, last_code}, 16'h0005);
        chk("k5_bcd", bcd, 16'h0005);
        chk("k5_col_held", {12'h0, col_n}, 16'h000D);
        rows_mask = 4'h0;
        slots(2);
        chk("k5_col_rel2", {12'h0, col_n}, 16'h000D);
        slots(1);
        chk("k5_col_rel3", {12'h0, col_n}, 16'h000B);
        slots(1);
        chk("k5_col_rel4", {12'h0, col_n}, 16'h0007);

        press_chk("d1", 0, 0, 4'd1, 16'h0051);
        press_chk("d2", 0, 1, 4'd2, 16'h0512);
        press_chk("d3", 0, 2, 4'd3, 16'h5123);
        press_chk("d4", 1, 0, 4'd4, 16'h1234);
        press_chk("d9", 2, 2, 4'd9, 16'h2349);

        press_chk("e1", 0, 0, 4'd1, 16'h3491);
        press_chk("e2", 0, 1, 4'd2, 16'h4912);
        press_chk("e3", 0, 2, 4'd3, 16'h9123);
        press_chk("e4", 1, 0, 4'd4, 16'h1234);
        press_chk("bksp", 1, 3, 4'd11, 16'h0123);
        press_chk("clr", 2, 3, 4'd12, 16'h0000);

        // Bounce on row 2 (key 7 column): 2 low, 1 high, 2 low, high.
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (col_n == 4'b1110) begin
                found = 1'b1;
                break;
            end
            slots(1);
        end
        chk("bnc_align", {15'h0, found}, 16'h0001);
        p0       = pulses;
        ovr_en   = 1'b1;
        ovr_rows = 4'b1011;
        slots(2);
        ovr_rows = 4'hF;
        slots(1);
        ovr_rows = 4'b1011;
        slots(2);
        ovr_rows = 4'hF;
        slots(1);
        chk("bnc_col_a", {12'h0, col_n}, 16'h000B);
        slots(1);
        chk("bnc_col_b", {12'h0, col_n}, 16'h0007);
        chk("bnc_pulses", 16'(pulses), 16'(p0));
        chk("bnc_bcd", bcd, 16'h0000);
        ovr_en = 1'b0;

        // Rows 0 and 2 together in column 1: row 0 wins, no repeat while held.
        p0        = pulses;
        rows_mask = 4'b0101;
        key_col   = 2'd1;
        slots(10);
        chk("multi_pulses", 16'(pulses), 16'(p0 + 1));
        chk("multi_code", {12'h0, last_code}, 16'h0002);
        slots(100);
        chk("multi_hold", 16'(pulses), 16'(p0 + 1));
        rows_mask = 4'h0;
        slots(5);
        chk("multi_bcd", bcd, 16'h0002);

        // Reset during DEBOUNCE on key 9.
        p0        = pulses;
        rows_mask = 4'b0100;
        key_col   = 2'd2;
        found     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (col_n == 4'b1011) begin
                found = 1'b1;
                break;
            end
            slots(1);
        end
        chk("deb_align", {15'h0, found}, 16'h0001);
        slots(2);
        chk("deb_col_held", {12'h0, col_n}, 16'h000B);
        #2 rst = 1'b1;
        #1;
        chk("deb_rst_col", {12'h0, col_n}, 16'h000E);
        chk("deb_rst_bcd", bcd, 16'h0000);
        chk("deb_rst_valid", {15'h0, key_valid}, 16'h0000);
        rows_mask = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        slots(10);
        chk("deb_no_event", 16'(pulses), 16'(p0));

        // Reset in the accept cycle.
        p0        = pulses;
        rows_mask = 4'b0100;
        key_col   = 2'd2;
        found     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("acc_seen", {15'h0, found}, 16'h0001);
        chk("acc_bcd", bcd, 16'h0009);
        #1 rst = 1'b1;
        #1;
        chk("acc_rst_valid", {15'h0, key_valid}, 16'h0000);
        chk("acc_rst_bcd", bcd, 16'h0000);
        chk("acc_rst_col", {12'h0, col_n}, 16'h000E);
        chk("acc_rst_code", {12'h0, key_code}, 16'h0000);
        rows_mask = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        slots(10);
        chk("acc_no_event", 16'(pulses), 16'(p0 + 1));

        press_chk("fresh4", 1, 0, 4'd4, 16'h0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
